// File: rtl/seqdetect_pkg.sv
// Shared types and defaults for the sequence-detector scheduler.
package seqdetect_pkg;

    localparam int          W_DEF     = 8;
    localparam int          CNT_W_DEF = 5;
    localparam logic [3:0]  PATTERN   = 4'b1011;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        SHIFT = 3'd2,
        WAIT  = 3'd3,
        RESP  = 3'd4
    } state_e;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seqdetect_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first requester after last_grant, with wrap.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last_grant,
    output logic [NREQ-1:0] grant_oh,
    output logic [IDW-1:0]  grant_idx,
    output logic            grant_any
);

    always_comb begin
        int idx;
        grant_oh  = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        idx       = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last_grant) + k) % NREQ;
            if (!grant_any && req[idx]) begin
                grant_any     = 1'b1;
                grant_oh[idx] = 1'b1;
                grant_idx     = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/seqdetect_sched.sv
// Round-robin scheduler sharing one serial 1011 detector among NREQ word requesters.
// Optional per-requester response counters: define SEQDETECT_SCHED_STATS_EN.
//
// state | meaning
// IDLE  | waiting for a request; grant issued combinationally
// CLR   | det_clr pulse, detector reset before the word
// SHIFT | W cycles, word streamed MSB-first on det_din
// WAIT  | DET_LAT cycles for det_cnt to settle; captured on the last one
// RESP  | rsp_valid held until rsp_ready
module seqdetect_sched
    import seqdetect_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int W       = W_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int DET_LAT = 1,
    localparam int IDW    = clog2_min1(NREQ)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*W-1:0]   req_data,
    output logic [NREQ-1:0]     req_ready,
    output logic                det_clr,
    output logic                det_din,
    input  logic [CNT_W-1:0]    det_cnt,
    output logic                rsp_valid,
    output logic [IDW-1:0]      rsp_id,
    output logic [CNT_W-1:0]    rsp_cnt,
    input  logic                rsp_ready,
`ifdef SEQDETECT_SCHED_STATS_EN
    output logic [NREQ*8-1:0]   stat_words,
`endif
    output logic                busy
);

    localparam int BW = clog2_min1(W);
    localparam int LW = clog2_min1(DET_LAT);

    state_e             state_q, state_d;
    logic [W-1:0]       shreg_q, shreg_d;
    logic [BW-1:0]      bit_cnt_q, bit_cnt_d;
    logic [LW-1:0]      wait_cnt_q, wait_cnt_d;
    logic [IDW-1:0]     last_grant_q, last_grant_d;
    logic [IDW-1:0]     rsp_id_q, rsp_id_d;
    logic [CNT_W-1:0]   rsp_cnt_q, rsp_cnt_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               det_clr_q, det_clr_d;
    logic               det_din_q, det_din_d;

    logic [NREQ-1:0]    grant_oh;
    logic [IDW-1:0]     grant_idx;
    logic               grant_any;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .grant_oh   (grant_oh),
        .grant_idx  (grant_idx),
        .grant_any  (grant_any)
    );

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        bit_cnt_d    = bit_cnt_q;
        wait_cnt_d   = wait_cnt_q;
        last_grant_d = last_grant_q;
        rsp_id_d     = rsp_id_q;
        rsp_cnt_d    = rsp_cnt_q;
        rsp_valid_d  = rsp_valid_q;
        det_clr_d    = 1'b0;
        det_din_d    = 1'b0;
        case (state_q)
            IDLE: if (grant_any) begin
                shreg_d      = req_data[int'(grant_idx)*W +: W];
                rsp_id_d     = grant_idx;
                last_grant_d = grant_idx;
                det_clr_d    = 1'b1;
                state_d      = CLR;
            end
            // Outputs are registered, so the first bit is staged while leaving CLR.
            CLR: begin
                det_din_d = shreg_q[W-1];
                shreg_d   = shreg_q << 1;
                bit_cnt_d = '0;
                state_d   = SHIFT;
            end
            SHIFT: if (bit_cnt_q == BW'(W-1)) begin
                wait_cnt_d = LW'(DET_LAT-1);
                state_d    = WAIT;
            end else begin
                det_din_d = shreg_q[W-1];
                shreg_d   = shreg_q << 1;
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
            WAIT: if (wait_cnt_q == '0) begin
                rsp_cnt_d   = det_cnt;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end else begin
                wait_cnt_d = wait_cnt_q - 1'b1;
            end
            RESP: if (rsp_ready) begin
                rsp_valid_d = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            bit_cnt_q    <= '0;
            wait_cnt_q   <= '0;
            last_grant_q <= IDW'(NREQ-1);
            rsp_id_q     <= '0;
            rsp_cnt_q    <= '0;
            rsp_valid_q  <= 1'b0;
            det_clr_q    <= 1'b0;
            det_din_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            bit_cnt_q    <= bit_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            last_grant_q <= last_grant_d;
            rsp_id_q     <= rsp_id_d;
            rsp_cnt_q    <= rsp_cnt_d;
            rsp_valid_q  <= rsp_valid_d;
            det_clr_q    <= det_clr_d;
            det_din_q    <= det_din_d;
        end
    end

    assign req_ready = (state_q == IDLE) ? grant_oh : '0;
    assign det_clr   = det_clr_q;
    assign det_din   = det_din_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_cnt   = rsp_cnt_q;
    assign busy      = (state_q != IDLE);

`ifdef SEQDETECT_SCHED_STATS_EN
    logic [7:0] stat_q [NREQ];
    logic [7:0] stat_d [NREQ];

    always_comb begin
        stat_d = stat_q;
        if (rsp_valid_q && rsp_ready && stat_q[rsp_id_q] != 8'hFF)
            stat_d[rsp_id_q] = stat_q[rsp_id_q] + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREQ; i++) stat_q[i] <= '0;
        end else begin
            stat_q <= stat_d;
        end
    end

    for (genvar g = 0; g < NREQ; g++) begin : g_stat
        assign stat_words[g*8 +: 8] = stat_q[g];
    end
`endif

endmodule

// File: tb/tb_seqdetect_sched.sv
// Self-checking bench for seqdetect_sched with a behavioural 1011 detector attached.
module tb_seqdetect_sched;
    import seqdetect_pkg::*;

    localparam int NREQ    = 2;
    localparam int W       = 8;
    localparam int CNT_W   = 5;
    localparam int DET_LAT = 1;
    localparam int IDW     = 1;
    localparam int LAT     = 2 + W + DET_LAT;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*W-1:0]   req_data;
    logic [NREQ-1:0]     req_ready;
    logic                det_clr;
    logic                det_din;
    logic [CNT_W-1:0]    det_cnt;
    logic                rsp_valid;
    logic [IDW-1:0]      rsp_id;
    logic [CNT_W-1:0]    rsp_cnt;
    logic                rsp_ready;
    logic                busy;
`ifdef SEQDETECT_SCHED_STATS_EN
    logic [NREQ*8-1:0]   stat_words;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int m_last;
    int m_stat [NREQ];

    seqdetect_sched #(.NREQ(NREQ), .W(W), .CNT_W(CNT_W), .DET_LAT(DET_LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .det_clr    (det_clr),
        .det_din    (det_din),
        .det_cnt    (det_cnt),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_cnt    (rsp_cnt),
        .rsp_ready  (rsp_ready),
`ifdef SEQDETECT_SCHED_STATS_EN
        .stat_words (stat_words),
`endif
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Stand-in detector: registered, cleared only by det_clr (not by rst).
    logic [3:0]       dhist = '0;
    logic [CNT_W-1:0] dcnt  = '0;
    always @(posedge clk) begin
        if (det_clr) begin
            dhist <= '0;
            dcnt  <= '0;
        end else begin
            dhist <= {dhist[2:0], det_din};
            if ({dhist[2:0], det_din} == PATTERN) dcnt <= dcnt + 1'b1;
        end
    end
    assign det_cnt = dcnt;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int ref_count(input logic [W-1:0] w);
        int c = 0;
        int v = int'(w);
        for (int i = 0; i <= W - 4; i++)
            if (((v >> i) & 15) == int'(PATTERN)) c++;
        return c % (1 << CNT_W);
    endfunction

    function automatic int ref_grant(input logic [NREQ-1:0] v, input int last);
        for (int k = 1; k <= NREQ; k++)
            if (v[(last + k) % NREQ]) return (last + k) % NREQ;
        return -1;
    endfunction

    // Called just after a rising edge with the DUT in IDLE; returns likewise.
    task automatic do_txn(input string tag, input logic [NREQ-1:0] vmask,
                          input logic [NREQ*W-1:0] data, input int bp);
        int g, ec, lat;
        req_valid = vmask;
        req_data  = data;
        rsp_ready = (bp == 0);
        #1;
        g  = ref_grant(vmask, m_last);
        ec = ref_count(data[g*W +: W]);
        check({tag, " req_ready"}, 32'(req_ready), 32'(1 << g));
        m_last = g;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (!rsp_valid) check({tag, " req_ready busy"}, 32'(req_ready), 32'd0);
        end while (!rsp_valid && lat < 40);
        check({tag, " latency"}, 32'(lat), 32'(LAT));
        check({tag, " rsp_id"}, 32'(rsp_id), 32'(g));
        check({tag, " rsp_cnt"}, 32'(rsp_cnt), 32'(ec));
        for (int i = 1; i < bp; i++) begin
            @(posedge clk); #1;
            check({tag, " hold rsp_valid"}, 32'(rsp_valid), 32'd1);
            check({tag, " hold rsp_id"}, 32'(rsp_id), 32'(g));
            check({tag, " hold rsp_cnt"}, 32'(rsp_cnt), 32'(ec));
            check({tag, " hold req_ready"}, 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, " rsp_valid drop"}, 32'(rsp_valid), 32'd0);
        check({tag, " busy drop"}, 32'(busy), 32'd0);
        req_valid = '0;
        if (m_stat[g] < 255) m_stat[g]++;
    endtask

    initial begin
        logic [NREQ-1:0] vm;
        logic [NREQ*W-1:0] dw;
        int seen;
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        rsp_ready = 1'b1;
        m_last    = NREQ - 1;
        for (int i = 0; i < NREQ; i++) m_stat[i] = 0;

        repeat (3) @(posedge clk);
        #1;
        check("rst req_ready", 32'(req_ready), 32'd0);
        check("rst det_clr", 32'(det_clr), 32'd0);
        check("rst det_din", 32'(det_din), 32'd0);
        check("rst rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst rsp_id", 32'(rsp_id), 32'd0);
        check("rst rsp_cnt", 32'(rsp_cnt), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        do_txn("single", 2'b01, {8'h00, 8'hBB}, 0);
        do_txn("zero", 2'b10, {8'h00, 8'hFF}, 0);
        for (int i = 0; i < 4; i++) do_txn("rr", 2'b11, {8'hBB, 8'h0B}, 0);
        do_txn("backpressure", 2'b01, {8'h00, 8'hB6}, 5);

        // Abort while bit 4 is on det_din.
        req_valid = 2'b01;
        req_data  = {8'h00, 8'hBB};
        #1;
        check("abort req_ready", 32'(req_ready), 32'd1);
        repeat (6) @(posedge clk);
        #1;
        check("abort det_clr in shift", 32'(det_clr), 32'd0);
        rst       = 1'b1;
        req_valid = '0;
        @(posedge clk); #1;
        check("abort rsp_valid", 32'(rsp_valid), 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        check("abort det_din", 32'(det_din), 32'd0);
        check("abort det_clr", 32'(det_clr), 32'd0);
        check("abort rsp_cnt", 32'(rsp_cnt), 32'd0);
        rst = 1'b0;
        `ifdef SEQDETECT_SCHED_STATS_EN
        for (int i = 0; i < NREQ; i++) m_stat[i] = 0;
        `endif
        m_last = NREQ - 1;
        seen = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (rsp_valid) seen++;
        end
        check("abort no response", 32'(seen), 32'd0);
        do_txn("after abort", 2'b11, {8'h00, 8'h0B}, 0);

        for (int i = 0; i < 30; i++) begin
            vm = NREQ'($urandom_range(1, 3));
            dw = {8'($urandom), 8'($urandom)};
            do_txn("random", vm, dw, int'($urandom_range(0, 3)));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

`ifdef SEQDETECT_SCHED_STATS_EN
        for (int i = 0; i < NREQ; i++)
            check("stat_words", 32'(stat_words[i*8 +: 8]), 32'(m_stat[i]));
        for (int i = 0; i < 260; i++)
            do_txn("saturate", 2'b01, {8'h00, 8'($urandom)}, 0);
        for (int i = 0; i < NREQ; i++)
            check("stat_words sat", 32'(stat_words[i*8 +: 8]), 32'(m_stat[i]));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
